// File: rtl/alu_seq_core.sv
// WIDTH-bit sequential ALU: operand/opcode registers, 16-op single-cycle ALU,
// and a shift-add multiplier behind a Start/Busy/Done handshake.
module alu_seq_core #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Ld,
   input  logic             Start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic [3:0]       Op_in,
   output logic [WIDTH-1:0] A_q,
   output logic [WIDTH-1:0] B_q,
   output logic [3:0]       Op_q,
   output logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] R_hi,
   output logic             Z,
   output logic             S,
   output logic             O,
   output logic             C,
   output logic             Busy,
   output logic             Done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_XNOR = 4'd3;
   localparam logic [3:0] OP_SHLA = 4'd4;
   localparam logic [3:0] OP_SHRA = 4'd5;
   localparam logic [3:0] OP_ROLA = 4'd6;
   localparam logic [3:0] OP_RORA = 4'd7;
   localparam logic [3:0] OP_SHLB = 4'd8;
   localparam logic [3:0] OP_SHRB = 4'd9;
   localparam logic [3:0] OP_ROLB = 4'd10;
   localparam logic [3:0] OP_RORB = 4'd11;
   localparam logic [3:0] OP_ADD  = 4'd12;
   localparam logic [3:0] OP_SUB  = 4'd13;
   localparam logic [3:0] OP_MUL  = 4'd14;
   localparam logic [3:0] OP_NOT  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic             c;
      logic             s;
      logic             o;
   } alu_res_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [3:0]         opcode_q, opcode_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic               zf_q, zf_d;
   logic               sf_q, sf_d;
   logic               of_q, of_d;
   logic               cf_q, cf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   alu_res_t           alu_res;

   // Single-cycle ops; MUL is handled by the sequencer, so it falls to default.
   function automatic alu_res_t alu_eval(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
      alu_res_t       res;
      logic [WIDTH:0] sum;
      res = '0;
      sum = '0;
      case (op)
         OP_AND:  res.r = a & b;
         OP_OR:   res.r = a | b;
         OP_XOR:  res.r = a ^ b;
         OP_XNOR: res.r = ~(a ^ b);
         OP_SHLA: begin
            res.r = {a[WIDTH-2:0], 1'b0};
            res.c = a[WIDTH-1];
         end
         OP_SHRA: begin
            res.r = {1'b0, a[WIDTH-1:1]};
            res.c = a[0];
         end
         OP_ROLA: begin
            res.r = {a[WIDTH-2:0], a[WIDTH-1]};
            res.c = a[WIDTH-1];
         end
         OP_RORA: begin
            res.r = {a[0], a[WIDTH-1:1]};
            res.c = a[0];
         end
         OP_SHLB: begin
            res.r = {b[WIDTH-2:0], 1'b0};
            res.c = b[WIDTH-1];
         end
         OP_SHRB: begin
            res.r = {1'b0, b[WIDTH-1:1]};
            res.c = b[0];
         end
         OP_ROLB: begin
            res.r = {b[WIDTH-2:0], b[WIDTH-1]};
            res.c = b[WIDTH-1];
         end
         OP_RORB: begin
            res.r = {b[0], b[WIDTH-1:1]};
            res.c = b[0];
         end
         OP_ADD: begin
            sum   = {1'b0, a} + {1'b0, b};
            res.r = sum[WIDTH-1:0];
            res.c = sum[WIDTH];
            res.o = sum[WIDTH];
         end
         OP_SUB: begin
            sum   = {1'b0, a} - {1'b0, b};
            res.r = sum[WIDTH-1:0];
            res.c = ~sum[WIDTH];
         end
         OP_NOT:  res.r = ~a;
         default: res = '0;
      endcase
      // For SUB the wrapped borrow bit is exactly the unsigned A<B test.
      res.s = (op == OP_SUB) ? sum[WIDTH] : res.r[WIDTH-1];
      return res;
   endfunction

   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   mcand,
                                                   input logic               add_en);
      logic [WIDTH:0] upper;
      upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (add_en ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      return {upper, acc[WIDTH-1:1]};
   endfunction

   assign alu_res = alu_eval(opcode_q, opa_q, opb_q);

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      opcode_d = opcode_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      zf_d     = zf_q;
      sf_d     = sf_q;
      of_d     = of_q;
      cf_d     = cf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (Ld) begin
               opa_d    = A_in;
               opb_d    = B_in;
               opcode_d = Op_in;
            end
            // Start consumes the pre-load register contents.
            if (Start) begin
               if (opcode_q == OP_MUL) begin
                  state_d  = ST_MUL;
                  acc_d    = '0;
                  mcand_d  = opa_q;
                  mplier_d = opb_q;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
               end else begin
                  res_d    = alu_res.r;
                  res_hi_d = '0;
                  zf_d     = (alu_res.r == '0);
                  sf_d     = alu_res.s;
                  of_d     = alu_res.o;
                  cf_d     = alu_res.c;
                  done_d   = 1'b1;
               end
            end
         end
         ST_MUL: begin
            acc_d    = mul_step(acc_q, mcand_q, mplier_q[0]);
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            res_d    = acc_q[WIDTH-1:0];
            res_hi_d = acc_q[2*WIDTH-1:WIDTH];
            zf_d     = (acc_q == '0);
            sf_d     = acc_q[WIDTH-1];
            of_d     = |acc_q[2*WIDTH-1:WIDTH];
            cf_d     = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         opcode_q <= '0;
         res_q    <= '0;
         res_hi_q <= '0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
         cf_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         opcode_q <= opcode_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
         of_q     <= of_d;
         cf_q     <= cf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign A_q  = opa_q;
   assign B_q  = opb_q;
   assign Op_q = opcode_q;
   assign R    = res_q;
   assign R_hi = res_hi_q;
   assign Z    = zf_q;
   assign S    = sf_q;
   assign O    = of_q;
   assign C    = cf_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized and directed bench for alu_seq_core at WIDTH=4 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_alu_seq_core;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   logic       ld4, st4;
   logic [3:0] a4, b4, op4;
   logic [3:0] aq4, bq4, opq4, r4, rh4;
   logic       z4, s4, o4, c4, busy4, done4;

   logic       ld8, st8;
   logic [7:0] a8, b8;
   logic [3:0] op8, opq8;
   logic [7:0] aq8, bq8, r8, rh8;
   logic       z8, s8, o8, c8, busy8, done8;

   alu_seq_core #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .Ld(ld4), .Start(st4),
      .A_in(a4), .B_in(b4), .Op_in(op4),
      .A_q(aq4), .B_q(bq4), .Op_q(opq4), .R(r4), .R_hi(rh4),
      .Z(z4), .S(s4), .O(o4), .C(c4), .Busy(busy4), .Done(done4)
   );

   alu_seq_core #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Reset(Reset), .Ld(ld8), .Start(st8),
      .A_in(a8), .B_in(b8), .Op_in(op8),
      .A_q(aq8), .B_q(bq8), .Op_q(opq8), .R(r8), .R_hi(rh8),
      .Z(z8), .S(s8), .O(o8), .C(c8), .Busy(busy8), .Done(done8)
   );

   typedef struct {
      int r, rhi, z, s, o, c, busy, done, aq, bq, opq;
   } obs_t;

   int n_chk  = 0;
   int n_pass = 0;
   int last_r[2] = '{0, 0};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive(input int w, input logic ld, input logic st,
                        input int a, input int b, input int op);
      if (w == 4) begin
         ld4 = ld; st4 = st; a4 = a[3:0]; b4 = b[3:0]; op4 = op[3:0];
      end else begin
         ld8 = ld; st8 = st; a8 = a[7:0]; b8 = b[7:0]; op8 = op[3:0];
      end
   endtask

   task automatic sample(input int w, output obs_t ob);
      if (w == 4) begin
         ob.r = int'(r4); ob.rhi = int'(rh4); ob.z = int'(z4); ob.s = int'(s4);
         ob.o = int'(o4); ob.c = int'(c4); ob.busy = int'(busy4); ob.done = int'(done4);
         ob.aq = int'(aq4); ob.bq = int'(bq4); ob.opq = int'(opq4);
      end else begin
         ob.r = int'(r8); ob.rhi = int'(rh8); ob.z = int'(z8); ob.s = int'(s8);
         ob.o = int'(o8); ob.c = int'(c8); ob.busy = int'(busy8); ob.done = int'(done8);
         ob.aq = int'(aq8); ob.bq = int'(bq8); ob.opq = int'(opq8);
      end
   endtask

   // Reference: opcode semantics written as plain integer arithmetic.
   task automatic model(input int w, input int op, input int a, input int b,
                        output int r, output int rhi, output int z,
                        output int s, output int o, output int c);
      int m, h, full;
      m = 1 << w;
      h = m / 2;
      r = 0; rhi = 0; c = 0; o = 0;
      case (op)
         0:  r = a & b;
         1:  r = a | b;
         2:  r = a ^ b;
         3:  r = (m - 1) - (a ^ b);
         4:  begin r = (a * 2) % m;          c = (a >= h) ? 1 : 0; end
         5:  begin r = a / 2;                c = a % 2; end
         6:  begin r = (a * 2) % m + a / h;  c = (a >= h) ? 1 : 0; end
         7:  begin r = a / 2 + (a % 2) * h;  c = a % 2; end
         8:  begin r = (b * 2) % m;          c = (b >= h) ? 1 : 0; end
         9:  begin r = b / 2;                c = b % 2; end
         10: begin r = (b * 2) % m + b / h;  c = (b >= h) ? 1 : 0; end
         11: begin r = b / 2 + (b % 2) * h;  c = b % 2; end
         12: begin full = a + b; r = full % m; c = (full >= m) ? 1 : 0; o = c; end
         13: begin r = (a - b + m) % m; c = (a >= b) ? 1 : 0; end
         14: begin full = a * b; r = full % m; rhi = full / m; o = (rhi != 0) ? 1 : 0; end
         default: r = (m - 1) - a;
      endcase
      z = (r == 0 && rhi == 0) ? 1 : 0;
      if (op == 13) s = (a < b) ? 1 : 0;
      else          s = (r >= h) ? 1 : 0;
   endtask

   task automatic run_op(input int w, input int op, input int a, input int b,
                         input string tag, output obs_t ob);
      int er, erh, ez, es, eo, ec, cyc, busy_n, idx;
      obs_t nx;
      idx = (w == 4) ? 0 : 1;
      model(w, op, a, b, er, erh, ez, es, eo, ec);
      @(negedge Clk);
      drive(w, 1'b1, 1'b0, a, b, op);
      @(negedge Clk);
      sample(w, ob);
      check({tag, ".a_q"}, ob.aq, a);
      check({tag, ".hold"}, ob.r, last_r[idx]);
      drive(w, 1'b0, 1'b1, a, b, op);
      @(negedge Clk);
      drive(w, 1'b0, 1'b0, a, b, op);
      cyc = 0;
      busy_n = 0;
      sample(w, ob);
      while (ob.done == 0 && cyc < 4 * w) begin
         if (ob.busy != 0) busy_n++;
         @(negedge Clk);
         cyc++;
         sample(w, ob);
      end
      check({tag, ".latency"}, cyc, (op == 14) ? w + 1 : 0);
      check({tag, ".busy_cycles"}, busy_n, (op == 14) ? w + 1 : 0);
      check({tag, ".busy_at_done"}, ob.busy, 0);
      check({tag, ".r"}, ob.r, er);
      check({tag, ".r_hi"}, ob.rhi, erh);
      check({tag, ".zsoc"}, ob.z * 8 + ob.s * 4 + ob.o * 2 + ob.c, ez * 8 + es * 4 + eo * 2 + ec);
      @(negedge Clk);
      sample(w, nx);
      check({tag, ".done_pulse"}, nx.done, 0);
      last_r[idx] = er;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      obs_t ob;
      int op, a, b, cyc;
      Reset = 1'b0;
      drive(4, 1'b0, 1'b0, 0, 0, 0);
      drive(8, 1'b0, 1'b0, 0, 0, 0);
      repeat (3) @(negedge Clk);
      sample(4, ob);
      check("rst.r", ob.r + ob.rhi, 0);
      check("rst.flags", ob.z + ob.s + ob.o + ob.c, 0);
      check("rst.busy_done", ob.busy + ob.done, 0);
      check("rst.operands", ob.aq + ob.bq + ob.opq, 0);
      Reset = 1'b1;

      run_op(4, 0, 'hC, 'hA, "and", ob);
      check("and.lit", ob.r * 2 + ob.s, 8 * 2 + 1);
      run_op(4, 12, 9, 8, "add_ovf", ob);
      check("add_ovf.lit", ob.r * 4 + ob.c * 2 + ob.o, 1 * 4 + 3);
      run_op(4, 12, 0, 0, "add_zero", ob);
      check("add_zero.lit", ob.z * 2 + ob.c, 2);
      run_op(4, 13, 3, 5, "sub_neg", ob);
      check("sub_neg.lit", ob.r * 4 + ob.s * 2 + ob.c, 'hE * 4 + 2);
      run_op(4, 13, 5, 5, "sub_eq", ob);
      check("sub_eq.lit", ob.z * 4 + ob.s * 2 + ob.c, 5);
      run_op(4, 6, 9, 0, "rol", ob);
      check("rol.lit", ob.r * 2 + ob.c, 3 * 2 + 1);
      run_op(4, 14, 15, 15, "mul_ff", ob);
      check("mul_ff.lit", ob.rhi * 32 + ob.r * 2 + ob.o, 'hE * 32 + 1 * 2 + 1);

      // Mid-multiply Start and Ld must both be dropped.
      @(negedge Clk);
      drive(4, 1'b1, 1'b0, 'h5, 'h6, 14);
      @(negedge Clk);
      drive(4, 1'b0, 1'b1, 'h5, 'h6, 14);
      @(negedge Clk);
      drive(4, 1'b0, 1'b0, 'h5, 'h6, 14);
      cyc = 0;
      sample(4, ob);
      while (ob.done == 0 && cyc < 20) begin
         if (cyc == 2) drive(4, 1'b1, 1'b1, 3, 2, 0);
         else          drive(4, 1'b0, 1'b0, 'h5, 'h6, 14);
         @(negedge Clk);
         cyc++;
         sample(4, ob);
      end
      drive(4, 1'b0, 1'b0, 0, 0, 0);
      check("mulign.latency", cyc, 5);
      check("mulign.r", ob.rhi * 16 + ob.r, 30);
      check("mulign.operands", ob.aq * 256 + ob.bq * 16 + ob.opq, 'h5 * 256 + 'h6 * 16 + 14);
      repeat (3) begin
         @(negedge Clk);
         sample(4, ob);
         check("mulign.no_queue", ob.busy * 2 + ob.done, 0);
      end
      last_r[0] = 'hE;

      // Ld together with Start: operation sees the old operands.
      @(negedge Clk);
      drive(4, 1'b1, 1'b0, 1, 2, 12);
      @(negedge Clk);
      drive(4, 1'b1, 1'b1, 7, 7, 2);
      @(negedge Clk);
      drive(4, 1'b0, 1'b0, 0, 0, 0);
      sample(4, ob);
      check("ldstart.done", ob.done, 1);
      check("ldstart.r_old", ob.r, 3);
      check("ldstart.newops", ob.aq * 256 + ob.bq * 16 + ob.opq, 7 * 256 + 7 * 16 + 2);
      drive(4, 1'b0, 1'b1, 0, 0, 0);
      @(negedge Clk);
      drive(4, 1'b0, 1'b0, 0, 0, 0);
      sample(4, ob);
      check("ldstart.r_new", ob.r * 2 + ob.z, 1);
      last_r[0] = 0;

      // Asynchronous reset in the middle of a multiply.
      @(negedge Clk);
      drive(4, 1'b1, 1'b0, 'hF, 'hF, 14);
      @(negedge Clk);
      drive(4, 1'b0, 1'b1, 'hF, 'hF, 14);
      @(negedge Clk);
      drive(4, 1'b0, 1'b0, 'hF, 'hF, 14);
      @(negedge Clk);
      sample(4, ob);
      check("mulrst.busy_before", ob.busy, 1);
      #2 Reset = 1'b0;
      #1 sample(4, ob);
      check("mulrst.r", ob.r + ob.rhi, 0);
      check("mulrst.flags", ob.z + ob.s + ob.o + ob.c, 0);
      check("mulrst.busy_done", ob.busy + ob.done, 0);
      check("mulrst.operands", ob.aq + ob.bq + ob.opq, 0);
      @(negedge Clk);
      sample(4, ob);
      check("mulrst.no_done", ob.done + ob.busy, 0);
      Reset = 1'b1;
      last_r[0] = 0;
      last_r[1] = 0;
      run_op(4, 14, 3, 4, "mul_after_rst", ob);
      check("mul_after_rst.lit", ob.rhi * 32 + ob.r * 2 + ob.o, 'hC * 2);

      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 15));
         a  = int'($urandom_range(0, 15));
         b  = int'($urandom_range(0, 15));
         run_op(4, op, a, b, $sformatf("rnd4_%0d_op%0d", i, op), ob);
      end

      run_op(8, 14, 'hFF, 'hFF, "mul8_ff", ob);
      check("mul8_ff.lit", ob.rhi * 256 + ob.r, 'hFE01);
      run_op(8, 5, 'h81, 0, "shr8", ob);
      check("shr8.lit", ob.r * 2 + ob.c, 'h40 * 2 + 1);
      for (int i = 0; i < 15; i++) begin
         op = int'($urandom_range(0, 15));
         a  = int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         run_op(8, op, a, b, $sformatf("rnd8_%0d_op%0d", i, op), ob);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, sequential successor of the 4-bit display ALU top.
- Operand/opcode registers, 16-op ALU and result/flag registers are generalised to WIDTH bits.
- Adds a Start/Busy/Done handshake and a multi-cycle shift-add multiplier that returns the full 2*WIDTH product.
- Sits between the switch/button front end and the hex/sign display drivers, which read the registered operand and result outputs.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter; derived, never overridden.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- Ld  input  1  load A_in, B_in, Op_in into the operand registers (replaces the Read strobe).
- Start  input  1  begin an operation on the registered operands.
- A_in  input  WIDTH  operand A.
- B_in  input  WIDTH  operand B.
- Op_in  input  4  opcode.
- A_q  output  WIDTH  registered A, for display.
- B_q  output  WIDTH  registered B, for display.
- Op_q  output  4  registered opcode, for display.
- R  output  WIDTH  result, low half.
- R_hi  output  WIDTH  upper product half; 0 for all non-MUL ops.
- Z  output  1  result-zero flag.
- S  output  1  sign/borrow flag.
- O  output  1  overflow flag.
- C  output  1  carry out.
- Busy  output  1  high while a multiply is in progress.
- Done  output  1  one-cycle pulse when R and the flags are updated.

Behaviour:
- Reset (Reset=0, async): every register and output clears to 0; FSM enters IDLE. Reset during MUL aborts the multiply with no Done pulse.
- Opcode map (applies to Op_q):
  - 0 AND, 1 OR, 2 XOR, 3 XNOR.
  - 4 SHL A, 5 SHR A (logical), 6 ROL A, 7 ROR A; all by 1.
  - 8 SHL B, 9 SHR B, 10 ROL B, 11 ROR B.
  - 12 ADD A+B, 13 SUB A-B, 14 MUL A*B (unsigned), 15 NOT A.
- Ld: accepted only when Busy=0; ignored while Busy=1.
- Ld and Start in the same IDLE cycle: the operation uses the pre-load register contents. The new values are captured on the same edge and serve the next operation.
- FSM states: IDLE, MUL, FIN.
- IDLE with Start=1 and Op_q != 14:
  - On that edge, R, R_hi and the flags are written; state stays IDLE.
  - Done=1 for the following cycle. Latency is 1 edge.
- IDLE with Start=1 and Op_q = 14:
  - On that edge, go to MUL; clear the 2*WIDTH accumulator; load multiplicand and multiplier copies; counter=0; Busy=1.
- MUL: each edge, if the multiplier LSB is set, add the multiplicand to the accumulator upper half; shift right; counter+1.
  - After WIDTH iterations, go to FIN.
- FIN: on that edge write R=product[WIDTH-1:0] and R_hi=product[2W-1:W]; update flags; Busy=0; Done=1 for the next cycle; return to IDLE.
- MUL total latency: WIDTH+1 edges from the Start edge to Done.
- Start while Busy=1 is ignored; no queueing.
- R, R_hi and the flags hold between operations.
- Flags are updated only on a result write:
  - Z=1 when R==0. For MUL, Z=1 only when both halves are 0.
  - C: ADD = carry out of bit W-1; SUB = NOT borrow (1 when A>=B); shifts = the bit shifted out; 0 otherwise.
  - S: SUB = 1 when A<B (unsigned); all other ops = R[WIDTH-1].
  - O: ADD = C; MUL = (R_hi!=0); 0 for all other ops.
- Arithmetic wraps modulo 2^WIDTH; MUL never wraps.

Test Plan (WIDTH=4 unless noted):
- Ld A=0xC, B=0xA, Op=0; then Start → one edge later R=0x8, Done pulses 1 cycle, Z=0, S=1, Busy never 1.
- ADD A=9, B=8 → R=0x1, C=1, O=1, Z=0. ADD A=0, B=0 → R=0, Z=1, C=0.
- SUB A=3, B=5 → R=0xE, S=1, C=0. SUB A=5, B=5 → R=0, Z=1, S=0, C=1. ROL A=0x9 (Op=6) → R=0x3, C=1.
- MUL A=0xF, B=0xF → Busy high 5 cycles, Done on edge 5, R=0x1, R_hi=0xE, O=1. A second Start and a Ld mid-multiply are both ignored (A_q unchanged).
- Reset pulled low at MUL iteration 2 → all outputs 0 immediately, no Done. After release, MUL 3*4 → R=0xC, R_hi=0, O=0.
- WIDTH=8: MUL 0xFF*0xFF → R=0x01, R_hi=0xFE, Done 9 edges after Start. SHR 0x81 (Op=5) → R=0x40, C=1.
